// File: rtl/tdm_demultiplexer.sv
// -----------------------------------------------------------------------------
// tdm_demultiplexer
//
// Receive end of a 4-way time-division multiplexed datapath. A frame is four
// valid beats (slot 0..3 -> channels A..D), and its first beat is marked by
// i_sof. Beats are collected in shadow registers. o_a..o_d update together
// only when slot 3 completes the frame, and o_frame_valid pulses at the same
// time. An SOF that arrives mid-frame discards the partial frame, raises
// o_frame_err and starts a new frame.
//
// Ports
//   i_clk          system clock, rising edge
//   i_rst_n        asynchronous active-low reset
//   i_din          multiplexed data beat (WIDTH bits)
//   i_din_valid    beat qualifier; when low the block stalls
//   i_sof          start of frame, qualified by i_din_valid
//   o_a..o_d       channels 0..3 of the last complete frame
//   o_sel          slot index the next accepted beat is written to
//   o_frame_valid  one-cycle pulse: o_a..o_d just updated
//   o_frame_err    one-cycle pulse: partial frame discarded by a mid-frame SOF
// -----------------------------------------------------------------------------
module tdm_demultiplexer #(
  parameter int WIDTH = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_din_valid,
  input  logic             i_sof,
  output logic [WIDTH-1:0] o_a,
  output logic [WIDTH-1:0] o_b,
  output logic [WIDTH-1:0] o_c,
  output logic [WIDTH-1:0] o_d,
  output logic [1:0]       o_sel,
  output logic             o_frame_valid,
  output logic             o_frame_err
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RECV = 1'b1
  } state_t;

  state_t           r_state;
  logic [1:0]       r_sel;
  // Slot 3 never needs a shadow: it goes straight to o_d on the completing edge.
  logic [WIDTH-1:0] r_shadow0;
  logic [WIDTH-1:0] r_shadow1;
  logic [WIDTH-1:0] r_shadow2;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_c;
  logic [WIDTH-1:0] r_d;
  logic             r_frame_valid;
  logic             r_frame_err;

  // Frame FSM: slot tracking, shadow capture, atomic output update and pulses.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= ST_IDLE;
      r_sel         <= 2'd0;
      r_shadow0     <= {WIDTH{1'b0}};
      r_shadow1     <= {WIDTH{1'b0}};
      r_shadow2     <= {WIDTH{1'b0}};
      r_a           <= {WIDTH{1'b0}};
      r_b           <= {WIDTH{1'b0}};
      r_c           <= {WIDTH{1'b0}};
      r_d           <= {WIDTH{1'b0}};
      r_frame_valid <= 1'b0;
      r_frame_err   <= 1'b0;
    end else begin
      // Pulses are single-cycle; they are re-asserted below only when earned.
      r_frame_valid <= 1'b0;
      r_frame_err   <= 1'b0;
      if (i_din_valid) begin
        case (r_state)
          ST_IDLE: begin
            // Beats without SOF are hunted past silently.
            if (i_sof) begin
              r_shadow0 <= i_din;
              r_sel     <= 2'd1;
              r_state   <= ST_RECV;
            end else begin
              r_sel     <= 2'd0;
              r_state   <= ST_IDLE;
            end
          end
          ST_RECV: begin
            if (i_sof) begin
              // Resynchronise: drop the partial frame, SOF beat becomes slot 0.
              r_frame_err <= 1'b1;
              r_shadow0   <= i_din;
              r_sel       <= 2'd1;
              r_state     <= ST_RECV;
            end else begin
              case (r_sel)
                2'd1: begin
                  r_shadow1 <= i_din;
                  r_sel     <= 2'd2;
                end
                2'd2: begin
                  r_shadow2 <= i_din;
                  r_sel     <= 2'd3;
                end
                2'd3: begin
                  r_a           <= r_shadow0;
                  r_b           <= r_shadow1;
                  r_c           <= r_shadow2;
                  r_d           <= i_din;
                  r_frame_valid <= 1'b1;
                  r_sel         <= 2'd0;
                  r_state       <= ST_IDLE;
                end
                default: begin
                  // Slot 0 is never legal in RECV; fall back to hunting.
                  r_sel   <= 2'd0;
                  r_state <= ST_IDLE;
                end
              endcase
            end
          end
          default: begin
            r_sel   <= 2'd0;
            r_state <= ST_IDLE;
          end
        endcase
      end else begin
        r_state <= r_state;
        r_sel   <= r_sel;
      end
    end
  end

  assign o_a           = r_a;
  assign o_b           = r_b;
  assign o_c           = r_c;
  assign o_d           = r_d;
  assign o_sel         = r_sel;
  assign o_frame_valid = r_frame_valid;
  assign o_frame_err   = r_frame_err;

endmodule

// File: tb/tb_tdm_demultiplexer.sv
module tb_tdm_demultiplexer;

  localparam int WIDTH = 2;

  logic             i_clk;
  logic             i_rst_n;
  logic [WIDTH-1:0] i_din;
  logic             i_din_valid;
  logic             i_sof;
  logic [WIDTH-1:0] o_a, o_b, o_c, o_d;
  logic [1:0]       o_sel;
  logic             o_frame_valid;
  logic             o_frame_err;

  int n_total = 0;
  int n_pass  = 0;

  tdm_demultiplexer #(.WIDTH(WIDTH)) dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_din         (i_din),
    .i_din_valid   (i_din_valid),
    .i_sof         (i_sof),
    .o_a           (o_a),
    .o_b           (o_b),
    .o_c           (o_c),
    .o_d           (o_d),
    .o_sel         (o_sel),
    .o_frame_valid (o_frame_valid),
    .o_frame_err   (o_frame_err)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Reference model: the current frame is simply the list of beats seen since SOF.
  logic [WIDTH-1:0] m_q[$];
  logic [WIDTH-1:0] m_a, m_b, m_c, m_d;
  logic [1:0]       m_sel;
  logic             m_fv, m_fe;

  wire [11:0] w_obs = {o_a, o_b, o_c, o_d, o_sel, o_frame_valid, o_frame_err};

  function automatic logic [11:0] exp_vec();
    return {m_a, m_b, m_c, m_d, m_sel, m_fv, m_fe};
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_a = '0; m_b = '0; m_c = '0; m_d = '0;
    m_sel = 2'd0; m_fv = 1'b0; m_fe = 1'b0;
  endtask

  task automatic model_beat(input logic [WIDTH-1:0] din, input logic v, input logic sof);
    m_fv = 1'b0;
    m_fe = 1'b0;
    if (v) begin
      if (sof) begin
        if (m_q.size() != 0) m_fe = 1'b1;
        m_q.delete();
        m_q.push_back(din);
      end else if (m_q.size() != 0) begin
        m_q.push_back(din);
        if (m_q.size() == 4) begin
          m_a = m_q[0]; m_b = m_q[1]; m_c = m_q[2]; m_d = m_q[3];
          m_fv = 1'b1;
          m_q.delete();
        end
      end
    end
    m_sel = 2'(m_q.size());
  endtask

  // One clock: drive, advance model with the edge, settle to sample point.
  // Encoding of a beat code: {valid, sof, din[1:0]}.
  task automatic drive_beat(input logic [3:0] code);
    i_din_valid = code[3];
    i_sof       = code[2];
    i_din       = code[1:0];
    @(posedge i_clk);
    model_beat(code[1:0], code[3], code[2]);
    #1;
  endtask

  task automatic apply_reset();
    i_rst_n = 1'b0;
    i_din_valid = 1'b0; i_sof = 1'b0; i_din = '0;
    model_reset();
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    n_total++;
    if (w_obs !== 12'h000) $display("FAIL reset_state: got %h expected %h", w_obs, 12'h000);
    else n_pass++;
  endtask

  task automatic test_basic();
    logic [3:0] seq [5];
    seq = '{4'b1100, 4'b1001, 4'b1001, 4'b1011, 4'b0000};
    for (int i = 0; i < 5; i++) begin
      drive_beat(seq[i]);
      n_total++;
      if (w_obs !== exp_vec()) $display("FAIL basic beat%0d: got %h expected %h", i, w_obs, exp_vec());
      else n_pass++;
      if (i == 3) begin
        n_total++;
        if ({o_a, o_b, o_c, o_d, o_sel, o_frame_valid} !== {2'b00, 2'b01, 2'b01, 2'b11, 2'd0, 1'b1})
          $display("FAIL basic_frame: got %b expected 0001011100 1", {o_a, o_b, o_c, o_d, o_sel, o_frame_valid});
        else n_pass++;
      end
    end
    n_total++;
    if (o_frame_valid !== 1'b0) $display("FAIL basic_pulse_width: got %b expected 0", o_frame_valid);
    else n_pass++;
  endtask

  task automatic test_gap();
    logic [3:0] seq [7];
    seq = '{4'b1100, 4'b1001, 4'b0000, 4'b0000, 4'b0110, 4'b1001, 4'b1011};
    for (int i = 0; i < 7; i++) begin
      drive_beat(seq[i]);
      n_total++;
      if (w_obs !== exp_vec()) $display("FAIL gap beat%0d: got %h expected %h", i, w_obs, exp_vec());
      else n_pass++;
      if (i >= 2 && i <= 4) begin
        n_total++;
        if (o_sel !== 2'd2) $display("FAIL gap_sel_hold: got %0d expected 2", o_sel);
        else n_pass++;
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] seq [8];
    seq = '{4'b1111, 4'b1010, 4'b1001, 4'b1000, 4'b1101, 4'b1001, 4'b1010, 4'b1011};
    for (int i = 0; i < 8; i++) begin
      drive_beat(seq[i]);
      n_total++;
      if (w_obs !== exp_vec()) $display("FAIL b2b beat%0d: got %h expected %h", i, w_obs, exp_vec());
      else n_pass++;
      if (i == 3 || i == 7) begin
        n_total++;
        if ({o_a, o_b, o_c, o_d} !== ((i == 3) ? 8'b11100100 : 8'b01011011))
          $display("FAIL b2b_frame%0d: got %b", i, {o_a, o_b, o_c, o_d});
        else n_pass++;
      end
    end
  endtask

  task automatic test_sof_midframe();
    logic [3:0] seq [6];
    apply_reset();
    seq = '{4'b1110, 4'b1011, 4'b1100, 4'b1001, 4'b1010, 4'b1011};
    for (int i = 0; i < 6; i++) begin
      drive_beat(seq[i]);
      n_total++;
      if (w_obs !== exp_vec()) $display("FAIL sof_mid beat%0d: got %h expected %h", i, w_obs, exp_vec());
      else n_pass++;
      if (i == 2) begin
        n_total++;
        if ({o_frame_err, o_frame_valid, o_a, o_b, o_c, o_d, o_sel} !== {1'b1, 1'b0, 8'h00, 2'd1})
          $display("FAIL sof_mid_err: got %b", {o_frame_err, o_frame_valid, o_a, o_b, o_c, o_d, o_sel});
        else n_pass++;
      end
    end
    n_total++;
    if ({o_a, o_b, o_c, o_d} !== 8'b00011011) $display("FAIL sof_mid_frame: got %b expected 00011011", {o_a, o_b, o_c, o_d});
    else n_pass++;
  endtask

  task automatic test_idle_discard();
    logic [3:0] seq [6];
    seq = '{4'b1011, 4'b1011, 4'b1100, 4'b1001, 4'b1001, 4'b1011};
    for (int i = 0; i < 6; i++) begin
      drive_beat(seq[i]);
      n_total++;
      if (w_obs !== exp_vec()) $display("FAIL idle beat%0d: got %h expected %h", i, w_obs, exp_vec());
      else n_pass++;
      if (i < 2) begin
        n_total++;
        if ({o_sel, o_frame_valid, o_frame_err} !== 4'b0000)
          $display("FAIL idle_nochange: got %b expected 0000", {o_sel, o_frame_valid, o_frame_err});
        else n_pass++;
      end
    end
  endtask

  task automatic test_async_reset_midframe();
    logic [3:0] seq [4];
    seq = '{4'b1100, 4'b1001, 4'b1001, 4'b1011};
    for (int i = 0; i < 4; i++) drive_beat(seq[i]);
    drive_beat(4'b1110);
    drive_beat(4'b1001);
    #2;
    i_rst_n = 1'b0;
    model_reset();
    #1;
    n_total++;
    if (w_obs !== 12'h000) $display("FAIL async_reset: got %h expected %h", w_obs, 12'h000);
    else n_pass++;
    i_din_valid = 1'b0; i_sof = 1'b0;
    @(negedge i_clk);
    i_rst_n = 1'b1;
    seq = '{4'b1110, 4'b1000, 4'b1011, 4'b1001};
    for (int i = 0; i < 4; i++) begin
      drive_beat(seq[i]);
      n_total++;
      if (w_obs !== exp_vec()) $display("FAIL post_reset beat%0d: got %h expected %h", i, w_obs, exp_vec());
      else n_pass++;
    end
  endtask

  task automatic test_random();
    logic [3:0] code;
    for (int i = 0; i < 400; i++) begin
      code[3]   = ($urandom_range(0, 3) != 0);
      code[2]   = ($urandom_range(0, 4) == 0);
      code[1:0] = 2'($urandom_range(0, 3));
      drive_beat(code);
      n_total++;
      if (w_obs !== exp_vec()) $display("FAIL random cyc%0d: got %h expected %h", i, w_obs, exp_vec());
      else n_pass++;
    end
  endtask

  initial begin
    i_rst_n = 1'b0;
    i_din = '0; i_din_valid = 1'b0; i_sof = 1'b0;
    model_reset();
    test_reset();
    test_basic();
    test_gap();
    test_back_to_back();
    test_sof_midframe();
    test_idle_discard();
    test_async_reset_midframe();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/tdm_demultiplexer.md
Name: tdm_demultiplexer

Overview:
- Receive end of the 4-way multiplexed 2-bit datapath: takes one time-multiplexed stream of slot beats and rebuilds the four parallel channels A, B, C and D.
- A frame is four valid beats in order: slot 0 (A), slot 1 (B), slot 2 (C), slot 3 (D). The first beat is marked by SOF.
- Beats go into shadow registers. Outputs A–D update atomically only when a full frame has been received, and FRAME_VALID pulses at the same time.
- Sits after the multiplexer/serial link. Feeds downstream logic that consumes the parallel channels.

Parameters:
- WIDTH, 2, bit width of each channel and of DIN.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- RST_N  input  1  asynchronous, active-low reset.
- DIN  input  WIDTH  multiplexed data beat.
- DIN_VALID  input  1  DIN/SOF are sampled only when high; when low the block stalls.
- SOF  input  1  start of frame; qualifies a slot-0 beat. Ignored when DIN_VALID is low.
- A  output  WIDTH  channel 0 (slot 0) of the last complete frame.
- B  output  WIDTH  channel 1 (slot 1) of the last complete frame.
- C  output  WIDTH  channel 2 (slot 2) of the last complete frame.
- D  output  WIDTH  channel 3 (slot 3) of the last complete frame.
- SEL  output  2  slot index the next accepted beat is written to (the receive-side mirror of the mux select).
- FRAME_VALID  output  1  one-cycle pulse: A–D were just updated with a complete frame.
- FRAME_ERR  output  1  one-cycle pulse: an SOF arrived mid-frame and the partial frame was discarded.

Behaviour:
- Reset (RST_N low, asynchronous assert, synchronous to CLK on release):
  - A, B, C, D, SEL and the shadow registers go to 0.
  - FRAME_VALID and FRAME_ERR go to 0.
  - FSM goes to IDLE.
- States: IDLE (hunting for SOF) and RECV (mid-frame, SEL = 1..3).
- In IDLE:
  - DIN_VALID & SOF: shadow[0] <= DIN, SEL <= 1, go to RECV.
  - DIN_VALID & !SOF: beat discarded, no error, stay in IDLE, SEL stays 0.
- In RECV, DIN_VALID & !SOF:
  - shadow[SEL] <= DIN.
  - If SEL < 3: SEL <= SEL + 1.
  - If SEL == 3: on the same edge, A <= shadow[0], B <= shadow[1], C <= shadow[2], D <= DIN. FRAME_VALID = 1 for exactly the following cycle. SEL <= 0 (wraps), go to IDLE.
- In RECV, DIN_VALID & SOF (including at the slot-3 position):
  - Partial frame discarded; A–D unchanged.
  - FRAME_ERR = 1 for exactly the following cycle.
  - The SOF beat is taken as the new slot 0: shadow[0] <= DIN, SEL <= 1, stay in RECV.
- DIN_VALID low in any state: no state, SEL or shadow change. Gaps of any length between beats are legal.
- Latency: A–D and FRAME_VALID are visible one cycle after the edge that samples the slot-3 beat.
- Back-to-back frames: an SOF on the cycle immediately after slot 3 is accepted with no bubble. Sustained throughput is one frame per 4 valid cycles.
- FRAME_VALID and FRAME_ERR are never high in the same cycle.
- A–D hold their values indefinitely between complete frames.
- Reset mid-frame: the partial frame is lost, outputs return to 0, and the next frame must start with SOF.

Test Plan:
1. Reset, then beats 00(SOF), 01, 01, 11 on consecutive cycles → after the 4th edge A=00, B=01, C=01, D=11, FRAME_VALID high for exactly 1 cycle, SEL back to 0.
2. Same frame with DIN_VALID low for 3 cycles between the B and C beats → identical outputs, FRAME_VALID delayed by 3 cycles, SEL holds 2 during the gap.
3. Frame 1: 11(SOF), 10, 01, 00. Then frame 2 immediately after: 01(SOF), 01, 10, 11 → A–D=11,10,01,00, then A–D=01,01,10,11. Two FRAME_VALID pulses 4 cycles apart; no FRAME_ERR.
4. 10(SOF), 11, then 00(SOF), 01, 10, 11 → FRAME_ERR pulse on the second SOF, A–D stay 0 until the complete frame, then A=00, B=01, C=10, D=11.
5. Beats 11, 11 with no SOF while in IDLE → no state change, SEL=0, no pulses. A following SOF frame decodes normally.
6. After a valid frame A–D=00,01,01,11, start a new frame, pull RST_N low asynchronously after 2 beats → A–D, SEL and pulses go to 0 immediately with no clock edge required; a subsequent full frame decodes correctly.
